// File: rtl/event_readout_ctrl.sv
// Event readout controller: drains fixed-length events from the circular
// event buffer RAM through a small credit-controlled skid FIFO onto a
// valid/ready stream, emitting one read_complete pulse per delivered event.
module event_readout_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int EVT_LEN = 32,
  parameter int FIFO_D  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              live_rising,
  input  logic [5:0]        n_pileup,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              read_complete,
  output logic              busy,
  output logic [11:0]       evt_num
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam int SW = CW + 1;
  // A full-ring event length truncates to zero, which is the correct modulo step.
  localparam logic [ADDR_W-1:0] EVT_STEP = ADDR_W'(EVT_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(EVT_LEN - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] idx_q;
  logic [11:0]       evtNum_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     wrPtr_q, rdPtr_q;
  logic [DATA_W-1:0] fifoData_q [FIFO_D];
  logic              fifoLast_q [FIFO_D];
  // Two-stage tags shadowing the RAM read latency; stage 2 lines up with returned data.
  logic              p1Valid_q, p1Last_q, p2Valid_q, p2Last_q;

  logic [1:0]        inFlight;
  logic [SW-1:0]     occupancySum;
  logic              creditOk, headValid, pop, hdrPush, issue, retPush, push, pushLast;
  logic              lastIdx;
  logic [15:0]       hdrWord;
  logic [DATA_W-1:0] pushData;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign inFlight     = {1'b0, p1Valid_q} + {1'b0, p2Valid_q};
  assign occupancySum = SW'(cnt_q) + SW'(inFlight);
  assign creditOk     = occupancySum < SW'(FIFO_D);
  assign headValid    = (cnt_q != '0);
  assign pop          = headValid && out_ready;
  assign lastIdx      = (idx_q == LAST_IDX);
  assign hdrPush      = (state_q == S_HEADER) && creditOk && !live_rising;
  assign issue        = (state_q == S_READ) && creditOk && !live_rising;
  assign retPush      = p2Valid_q;
  assign push         = hdrPush || retPush;
  assign hdrWord      = {4'hA, evtNum_q};
  assign pushData     = hdrPush ? DATA_W'(hdrWord) : mem_rd_data;
  assign pushLast     = retPush && p2Last_q;

  assign mem_rd_en     = issue;
  assign mem_rd_addr   = base_q + idx_q;
  assign out_valid     = headValid;
  assign out_data      = headValid ? fifoData_q[rdPtr_q] : '0;
  assign out_last      = headValid ? fifoLast_q[rdPtr_q] : 1'b0;
  assign read_complete = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign evt_num       = evtNum_q;

  // Next-state logic; DRAIN exits on the very cycle the last payload word is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (n_pileup != 6'd0 && n_pileup != 6'h3F && !live_rising) state_d = S_HEADER;
      S_HEADER: if (hdrPush) state_d = S_READ;
      S_READ:   if (issue && lastIdx) state_d = S_DRAIN;
      S_DRAIN:  if (!p1Valid_q && !p2Valid_q && pop && out_last) state_d = S_DONE;
      S_DONE:   state_d = S_GAP;
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control state; a live_rising flush clears the same state as reset, and
  // clearing the read tags drops any data still returning from the RAM.
  always_ff @(posedge clk) begin
    if (!rst_n || live_rising) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      idx_q     <= '0;
      evtNum_q  <= '0;
      cnt_q     <= '0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      p1Valid_q <= 1'b0;
      p1Last_q  <= 1'b0;
      p2Valid_q <= 1'b0;
      p2Last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      p1Valid_q <= issue;
      p1Last_q  <= issue && lastIdx;
      p2Valid_q <= p1Valid_q;
      p2Last_q  <= p1Last_q;
      if (issue) begin
        idx_q <= lastIdx ? '0 : idx_q + ADDR_W'(1);
      end
      if (state_q == S_DONE) begin
        base_q   <= base_q + EVT_STEP;
        evtNum_q <= evtNum_q + 12'd1;
        idx_q    <= '0;
      end
      if (push) wrPtr_q <= nextPtr(wrPtr_q);
      if (pop)  rdPtr_q <= nextPtr(rdPtr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage needs no reset; the outputs are masked whenever it is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoData_q[wrPtr_q] <= pushData;
      fifoLast_q[wrPtr_q] <= pushLast;
    end
  end

endmodule

// File: tb/tb_event_readout_ctrl.sv
// Directed self-checking bench for event_readout_ctrl with a 2-cycle RAM
// model returning the read address as data and a pile-up counter model.
module tb_event_readout_ctrl;

  localparam int EVT = 32;

  logic        clk = 1'b0;
  logic        rst_n, live_rising, out_ready;
  logic [5:0]  n_pileup;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] out_data;
  logic        out_valid, out_last, read_complete, busy;
  logic [11:0] evt_num;

  int testCount = 0;
  int failCount = 0;
  int cycleNum = 0, rcCount = 0, rcCyc = 0, issueCount = 0, payloadXfers = 0;
  logic [16:0] words[$];
  int          xferCyc[$];
  logic        prevStall = 1'b0;
  logic [16:0] prevWord;
  bit          randomReady = 0, checkCredit = 0, sawBusy = 0, sawRd = 0;
  logic        busyS, rdValidS;
  logic [9:0]  rdAddrS;
  logic [5:0]  pending = 6'd0;
  logic [15:0] ramStage;

  event_readout_ctrl dut (
    .clk(clk), .rst_n(rst_n), .live_rising(live_rising), .n_pileup(n_pileup),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .read_complete(read_complete), .busy(busy), .evt_num(evt_num)
  );

  always #5 clk = ~clk;

  // RAM: data equals the address, valid exactly two cycles after the strobe.
  always @(posedge clk) begin
    ramStage    <= mem_rd_en ? {6'b0, mem_rd_addr} : 16'hDEAD;
    mem_rd_data <= ramStage;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic live, input logic ready);
    rst_n       = rstN;
    live_rising = live;
    out_ready   = ready;
  endtask

  // One clock: sample at negedge, then drive the next inputs just after posedge.
  task automatic tick();
    @(negedge clk);
    cycleNum++;
    if (prevStall) begin
      checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("stall_hold", {15'b0, out_last, out_data}, {15'b0, prevWord});
    end
    prevStall = out_valid && !out_ready;
    prevWord  = {out_last, out_data};
    if (out_valid && out_ready) begin
      words.push_back({out_last, out_data});
      xferCyc.push_back(cycleNum);
      if (out_data[15:12] != 4'hA) payloadXfers++;
    end
    if (mem_rd_en) issueCount++;
    if (checkCredit) checkOutput("credit", {31'b0, (issueCount - payloadXfers) <= 4}, 32'd1);
    if (read_complete) begin
      rcCount++;
      rcCyc = cycleNum;
      if (pending != 6'd0 && pending != 6'h3F) pending--;
    end
    busyS    = busy;
    rdValidS = mem_rd_en;
    rdAddrS  = mem_rd_addr;
    if (busy) sawBusy = 1;
    if (mem_rd_en) sawRd = 1;
    @(posedge clk);
    #1;
    n_pileup = pending;
    if (randomReady) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic doReset();
    pending = 6'd0;
    n_pileup = 6'd0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1);
    words.delete();
    xferCyc.delete();
    rcCount = 0; issueCount = 0; payloadXfers = 0;
    prevStall = 1'b0; sawBusy = 0; sawRd = 0;
  endtask

  task automatic waitEvents(input int target, input int budget);
    int b = 0;
    while (rcCount < target && b < budget) begin
      tick();
      b++;
    end
    checkOutput("evt_count", rcCount, target);
  endtask

  task automatic waitIssue(input logic [9:0] addr, input int budget);
    int b = 0;
    bit found = 0;
    while (!found && b < budget) begin
      tick();
      found = rdValidS && (rdAddrS == addr);
      b++;
    end
    checkOutput($sformatf("issue_%0d", addr), {31'b0, found}, 32'd1);
  endtask

  task automatic checkEvent(input int first, input int evtIdx, input int base);
    logic [16:0] exp, obs;
    exp = {1'b0, 4'hA, 12'(evtIdx)};
    obs = (first < words.size()) ? words[first] : 17'h1FFFF;
    checkOutput($sformatf("hdr_e%0d", evtIdx), {15'b0, obs}, {15'b0, exp});
    for (int i = 0; i < EVT; i++) begin
      exp = {(i == EVT - 1), 16'((base + i) % 1024)};
      obs = (first + 1 + i < words.size()) ? words[first + 1 + i] : 17'h1FFFF;
      checkOutput($sformatf("word_e%0d_%0d", evtIdx, i), {15'b0, obs}, {15'b0, exp});
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 1'b1);
    n_pileup = 6'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_rc", {31'b0, read_complete}, 32'd0);
    checkOutput("rst_evt", {20'b0, evt_num}, 32'd0);
    checkOutput("rst_data", {16'b0, out_data}, 32'd0);
    @(posedge clk); #1;

    // Single event, free-flowing output.
    doReset();
    pending = 6'd1;
    waitEvents(1, 200);
    checkOutput("e1_len", words.size(), EVT + 1);
    checkEvent(0, 0, 0);
    checkOutput("e1_latency", (xferCyc.size() > 1) ? xferCyc[1] - xferCyc[0] : -1, 3);
    checkOutput("e1_rc_timing", (xferCyc.size() > EVT) ? rcCyc - xferCyc[EVT] : -1, 1);
    checkOutput("e1_evt_num", {20'b0, evt_num}, 32'd1);
    tick();
    checkOutput("e1_gap_busy", {31'b0, busyS}, 32'd1);
    tick();
    checkOutput("e1_idle_busy", {31'b0, busyS}, 32'd0);

    // Three back-to-back events.
    doReset();
    pending = 6'd3;
    waitEvents(3, 400);
    checkOutput("e3_len", words.size(), 3 * (EVT + 1));
    for (int e = 0; e < 3; e++) checkEvent(e * (EVT + 1), e, e * EVT);
    checkOutput("e3_evt_num", {20'b0, evt_num}, 32'd3);

    // Random backpressure: stall stability and credit bound checked every cycle.
    doReset();
    pending = 6'd2;
    randomReady = 1;
    checkCredit = 1;
    waitEvents(2, 1500);
    randomReady = 0;
    checkCredit = 0;
    out_ready = 1'b1;
    checkOutput("rnd_len", words.size(), 2 * (EVT + 1));
    checkEvent(0, 0, 0);
    checkEvent(EVT + 1, 1, EVT);

    // Base pointer wraps around the 1024-word ring after 32 events.
    doReset();
    pending = 6'd33;
    waitEvents(33, 2500);
    checkOutput("wrap_len", words.size(), 33 * (EVT + 1));
    checkEvent(32 * (EVT + 1), 32, 0);

    // live_rising in the middle of an event's reads.
    doReset();
    pending = 6'd2;
    waitEvents(1, 200);
    waitIssue(10'd41, 200);
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1);
    pending = 6'd1;
    words.delete();
    checkOutput("live_rc", rcCount, 1);
    checkOutput("live_evt_num", {20'b0, evt_num}, 32'd0);
    checkOutput("live_busy", {31'b0, busy}, 32'd0);
    waitEvents(2, 200);
    checkOutput("live_len", words.size(), EVT + 1);
    checkEvent(0, 0, 0);

    // Reset while draining the second event.
    doReset();
    pending = 6'd2;
    waitEvents(1, 200);
    waitIssue(10'd63, 200);
    applyStimulus(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("drain_busy", {31'b0, busy}, 32'd1);
    checkOutput("drain_evt", {20'b0, evt_num}, 32'd1);
    @(negedge clk);
    checkOutput("rstd_busy", {31'b0, busy}, 32'd0);
    checkOutput("rstd_evt", {20'b0, evt_num}, 32'd0);
    checkOutput("rstd_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstd_data", {16'b0, out_data}, 32'd0);
    checkOutput("rstd_last", {31'b0, out_last}, 32'd0);
    checkOutput("rstd_rd_en", {31'b0, mem_rd_en}, 32'd0);
    checkOutput("rstd_addr", {22'b0, mem_rd_addr}, 32'd0);
    checkOutput("rstd_rc", {31'b0, read_complete}, 32'd0);
    @(posedge clk); #1;

    // Underflow marker means nothing to read.
    doReset();
    pending = 6'h3F;
    for (int i = 0; i < 60; i++) tick();
    checkOutput("uf_busy", {31'b0, sawBusy}, 32'd0);
    checkOutput("uf_rd_en", {31'b0, sawRd}, 32'd0);
    checkOutput("uf_rc", rcCount, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
